// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the JVM bytecode decode stage.
package decode_pkg;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_CONSTPUSH, CLS_ARGPUSH, CLS_LDC, CLS_LVAREAD, CLS_LVAWRITE,
        CLS_ARRREAD, CLS_ARRWRITE, CLS_NEWARRAY, CLS_POP, CLS_DUP, CLS_ALU,
        CLS_IINC, CLS_CMP, CLS_GOTO, CLS_RETURN
    } instr_class_e;

    localparam logic [7:0] OP_NOP       = 8'h00, OP_ICONST_M1 = 8'h02, OP_ICONST_0  = 8'h03,
                           OP_ICONST_5  = 8'h08, OP_BIPUSH    = 8'h10, OP_SIPUSH    = 8'h11,
                           OP_LDC       = 8'h12, OP_LDC_W     = 8'h13, OP_ILOAD     = 8'h15,
                           OP_ALOAD     = 8'h19, OP_ILOAD_0   = 8'h1A, OP_ILOAD_3   = 8'h1D,
                           OP_ALOAD_0   = 8'h2A, OP_ALOAD_3   = 8'h2D, OP_IALOAD    = 8'h2E,
                           OP_ISTORE    = 8'h36, OP_ASTORE    = 8'h3A, OP_ISTORE_0  = 8'h3B,
                           OP_ISTORE_3  = 8'h3E, OP_ASTORE_0  = 8'h4B, OP_ASTORE_3  = 8'h4E,
                           OP_IASTORE   = 8'h4F, OP_POP       = 8'h57, OP_DUP       = 8'h59,
                           OP_IADD      = 8'h60, OP_ISUB      = 8'h64, OP_IMUL      = 8'h68,
                           OP_INEG      = 8'h74, OP_ISHL      = 8'h78, OP_ISHR      = 8'h7A,
                           OP_IUSHR     = 8'h7C, OP_IAND      = 8'h7E, OP_IOR       = 8'h80,
                           OP_IXOR      = 8'h82, OP_IINC      = 8'h84, OP_IFEQ      = 8'h99,
                           OP_IFLE      = 8'h9E, OP_IF_ICMPEQ = 8'h9F, OP_IF_ICMPLE = 8'hA4,
                           OP_GOTO      = 8'hA7, OP_IRETURN   = 8'hAC, OP_RETURN    = 8'hB1,
                           OP_NEWARRAY  = 8'hBC, OP_WIDE      = 8'hC4;

    // Compare condition in cmptype[2:0]; cmptype[3] marks the two-operand IF_ICMP forms.
    localparam logic [2:0] CMP_EQ = 3'd0, CMP_NE = 3'd1, CMP_LT = 3'd2,
                           CMP_GE = 3'd3, CMP_GT = 3'd4, CMP_LE = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_MUL = 4'd2, ALU_NEG = 4'd3,
                           ALU_SHL = 4'd4, ALU_SHR = 4'd5, ALU_USHR = 4'd6, ALU_AND = 4'd7,
                           ALU_OR  = 4'd8, ALU_XOR = 4'd9;

    // Control fields produced per opcode; lvaidx holds the implicit (_N) index only.
    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   aluop;
        logic [3:0]   cmptype;
        logic [15:0]  lvaidx;
        logic [2:0]   constval;
        logic [2:0]   argc;
        logic [1:0]   stackargs;
        logic         stackwb;
        logic         illegal;
    } dec_bundle_t;

endpackage

// File: rtl/opcode_classifier.sv
// Pure combinational opcode (+WIDE flag) to control-bundle lookup.
module opcode_classifier
    import decode_pkg::*;
#(
    parameter int MAX_ARGS = 4
) (
    input  logic [7:0]  opcode_i,
    input  logic        wide_i,
    output dec_bundle_t ctl_o
);

    dec_bundle_t c;

    // Table lookup; anything unlisted falls to an all-zero illegal NOP.
    always_comb begin
        c = '0;
        case (opcode_i) inside
            OP_NOP: ;
            [OP_ICONST_M1:OP_ICONST_5]: begin
                c.cls = CLS_CONSTPUSH; c.constval = 3'(opcode_i - OP_ICONST_0); c.stackwb = 1'b1;
            end
            OP_BIPUSH:   begin c.cls = CLS_ARGPUSH; c.argc = 3'd1; c.stackwb = 1'b1; end
            OP_SIPUSH:   begin c.cls = CLS_ARGPUSH; c.argc = 3'd2; c.stackwb = 1'b1; end
            OP_LDC:      begin c.cls = CLS_LDC; c.argc = 3'd1; c.stackwb = 1'b1; end
            OP_LDC_W:    begin c.cls = CLS_LDC; c.argc = 3'd2; c.stackwb = 1'b1; end
            OP_ILOAD, OP_ALOAD: begin c.cls = CLS_LVAREAD; c.argc = 3'd1; c.stackwb = 1'b1; end
            [OP_ILOAD_0:OP_ILOAD_3]: begin
                c.cls = CLS_LVAREAD; c.lvaidx = 16'(opcode_i - OP_ILOAD_0); c.stackwb = 1'b1;
            end
            [OP_ALOAD_0:OP_ALOAD_3]: begin
                c.cls = CLS_LVAREAD; c.lvaidx = 16'(opcode_i - OP_ALOAD_0); c.stackwb = 1'b1;
            end
            OP_IALOAD:   begin c.cls = CLS_ARRREAD; c.stackargs = 2'd2; c.stackwb = 1'b1; end
            OP_ISTORE, OP_ASTORE: begin c.cls = CLS_LVAWRITE; c.argc = 3'd1; c.stackargs = 2'd1; end
            [OP_ISTORE_0:OP_ISTORE_3]: begin
                c.cls = CLS_LVAWRITE; c.lvaidx = 16'(opcode_i - OP_ISTORE_0); c.stackargs = 2'd1;
            end
            [OP_ASTORE_0:OP_ASTORE_3]: begin
                c.cls = CLS_LVAWRITE; c.lvaidx = 16'(opcode_i - OP_ASTORE_0); c.stackargs = 2'd1;
            end
            OP_IASTORE:  begin c.cls = CLS_ARRWRITE; c.stackargs = 2'd3; end
            OP_POP:      begin c.cls = CLS_POP; c.stackargs = 2'd1; end
            OP_DUP:      begin c.cls = CLS_DUP; c.stackargs = 2'd1; c.stackwb = 1'b1; end
            OP_IADD:     begin c.cls = CLS_ALU; c.aluop = ALU_ADD; end
            OP_ISUB:     begin c.cls = CLS_ALU; c.aluop = ALU_SUB; end
            OP_IMUL:     begin c.cls = CLS_ALU; c.aluop = ALU_MUL; end
            OP_INEG:     begin c.cls = CLS_ALU; c.aluop = ALU_NEG; end
            OP_ISHL:     begin c.cls = CLS_ALU; c.aluop = ALU_SHL; end
            OP_ISHR:     begin c.cls = CLS_ALU; c.aluop = ALU_SHR; end
            OP_IUSHR:    begin c.cls = CLS_ALU; c.aluop = ALU_USHR; end
            OP_IAND:     begin c.cls = CLS_ALU; c.aluop = ALU_AND; end
            OP_IOR:      begin c.cls = CLS_ALU; c.aluop = ALU_OR; end
            OP_IXOR:     begin c.cls = CLS_ALU; c.aluop = ALU_XOR; end
            OP_IINC:     begin c.cls = CLS_IINC; c.argc = 3'd2; end
            [OP_IFEQ:OP_IFLE]: begin
                c.cls = CLS_CMP; c.argc = 3'd2; c.stackargs = 2'd1;
                c.cmptype = {1'b0, 3'(opcode_i - OP_IFEQ)};
            end
            [OP_IF_ICMPEQ:OP_IF_ICMPLE]: begin
                c.cls = CLS_CMP; c.argc = 3'd2; c.stackargs = 2'd2;
                c.cmptype = {1'b1, 3'(opcode_i - OP_IF_ICMPEQ)};
            end
            OP_GOTO:     begin c.cls = CLS_GOTO; c.argc = 3'd2; end
            OP_IRETURN:  begin c.cls = CLS_RETURN; c.stackargs = 2'd1; end
            OP_RETURN:   begin c.cls = CLS_RETURN; end
            OP_NEWARRAY: begin c.cls = CLS_NEWARRAY; c.argc = 3'd1; c.stackargs = 2'd1; c.stackwb = 1'b1; end
            default:     c.illegal = 1'b1;
        endcase
        if (c.cls == CLS_ALU) begin
            c.stackargs = (opcode_i == OP_INEG) ? 2'd1 : 2'd2;
            c.stackwb   = 1'b1;
        end
        // WIDE only widens the index of the three local-variable ops.
        if (wide_i) begin
            case (opcode_i)
                OP_ILOAD, OP_ISTORE: c.argc = 3'd2;
                OP_IINC:             c.argc = 3'd4;
                default: begin c = '0; c.illegal = 1'b1; end
            endcase
        end
        // Operand count the stage cannot hold becomes an illegal instruction.
        if (int'(c.argc) > MAX_ARGS) begin
            c = '0;
            c.illegal = 1'b1;
        end
    end

    assign ctl_o = c;

endmodule

// File: rtl/bytecode_decode_stage.sv
// Handshaked JVM bytecode decode stage: assembles opcode, WIDE prefix and operand bytes
// into one registered decoded bundle with its PC.
module bytecode_decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int MAX_ARGS    = 4,
    parameter int LVA_W       = 8,
    parameter bit ENABLE_WIDE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_byte_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    flush_i,
    input  logic [PC_W-1:0]         flush_pc_i,
    output logic                    dec_valid_o,
    input  logic                    dec_ready_i,
    output logic [PC_W-1:0]         dec_pc_o,
    output instr_class_e            dec_class_o,
    output logic [3:0]              dec_aluop_o,
    output logic [3:0]              dec_cmptype_o,
    output logic [LVA_W-1:0]        dec_lvaidx_o,
    output logic [2:0]              dec_constval_o,
    output logic [8*MAX_ARGS-1:0]   dec_operand_o,
    output logic [2:0]              dec_argc_o,
    output logic [1:0]              dec_stackargs_o,
    output logic                    dec_stackwb_o,
    output logic                    dec_wide_o,
    output logic                    dec_illegal_o
);

    localparam int OPD_W = 8*MAX_ARGS;
    localparam logic [1:0] S_OPC = 2'd0, S_WIDE = 2'd1, S_ARG = 2'd2, S_OUT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, ipc_q, ipc_d, out_pc_q, out_pc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [OPD_W-1:0] opd_q, opd_d, out_opd_q, out_opd_d;
    dec_bundle_t      hdr_q, hdr_d, out_q, out_d, ctl, fin_ctl;
    logic             wide_q, wide_d, out_wide_q, out_wide_d;

    logic             xfer, fin, fin_wide, lva_opd;
    logic [OPD_W-1:0] opd_full, fin_opd;
    logic [5:0]       shamt;
    logic [15:0]      lva_sh, fin_lva;

    assign in_ready_o = rst_n && (state_q != S_OUT) && !flush_i;
    assign xfer       = in_valid_i && in_ready_o;
    assign opd_full   = (opd_q << 8) | OPD_W'(in_byte_i);

    opcode_classifier #(.MAX_ARGS(MAX_ARGS)) u_cls (
        .opcode_i (in_byte_i),
        .wide_i   (state_q == S_WIDE),
        .ctl_o    (ctl)
    );

    // Bundle source when the instruction completes: live lookup or the held header.
    always_comb begin
        fin_ctl  = (state_q == S_ARG) ? hdr_q : ctl;
        fin_opd  = (state_q == S_ARG) ? opd_full : '0;
        fin_wide = (state_q != S_OPC) && wide_q;
        // Implicit-index forms carry no operand; explicit ones index from operand byte 0.
        lva_opd  = (fin_ctl.cls == CLS_LVAREAD || fin_ctl.cls == CLS_LVAWRITE ||
                    fin_ctl.cls == CLS_IINC) && (fin_ctl.argc != 3'd0);
        shamt    = {fin_ctl.argc - (fin_wide ? 3'd2 : 3'd1), 3'b000};
        lva_sh   = 16'(fin_opd >> shamt);
        fin_lva  = !lva_opd ? fin_ctl.lvaidx :
                   fin_wide ? lva_sh : {8'h00, lva_sh[7:0]};
    end

    // Next-state: flush wins, otherwise walk opcode / wide / operand / output.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        cnt_d      = cnt_q;
        opd_d      = opd_q;
        hdr_d      = hdr_q;
        wide_d     = wide_q;
        out_d      = out_q;
        out_opd_d  = out_opd_q;
        out_pc_d   = out_pc_q;
        out_wide_d = out_wide_q;
        fin        = 1'b0;
        if (flush_i) begin
            state_d = S_OPC;
            pc_d    = flush_pc_i;
            cnt_d   = '0;
            opd_d   = '0;
            wide_d  = 1'b0;
        end else begin
            case (state_q)
                S_OPC, S_WIDE: if (xfer) begin
                    pc_d = pc_q + 1'b1;
                    if (state_q == S_OPC) begin
                        ipc_d  = pc_q;
                        opd_d  = '0;
                        wide_d = 1'b0;
                    end
                    if (state_q == S_OPC && ENABLE_WIDE && in_byte_i == OP_WIDE) begin
                        wide_d  = 1'b1;
                        state_d = S_WIDE;
                    end else begin
                        hdr_d = ctl;
                        if (ctl.argc == 3'd0) begin
                            fin = 1'b1;
                        end else begin
                            cnt_d   = ctl.argc;
                            state_d = S_ARG;
                        end
                    end
                end
                S_ARG: if (xfer) begin
                    pc_d  = pc_q + 1'b1;
                    opd_d = opd_full;
                    cnt_d = cnt_q - 3'd1;
                    fin   = (cnt_q == 3'd1);
                end
                default: if (dec_ready_i) state_d = S_OPC;
            endcase
        end
        if (fin) begin
            state_d        = S_OUT;
            out_d          = fin_ctl;
            out_d.lvaidx   = fin_lva;
            out_opd_d      = fin_opd;
            out_pc_d       = (state_q == S_OPC) ? pc_q : ipc_q;
            out_wide_d     = fin_wide;
        end
    end

    // State and output registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OPC;
            pc_q       <= '0;
            ipc_q      <= '0;
            cnt_q      <= '0;
            opd_q      <= '0;
            hdr_q      <= '0;
            wide_q     <= 1'b0;
            out_q      <= '0;
            out_opd_q  <= '0;
            out_pc_q   <= '0;
            out_wide_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            cnt_q      <= cnt_d;
            opd_q      <= opd_d;
            hdr_q      <= hdr_d;
            wide_q     <= wide_d;
            out_q      <= out_d;
            out_opd_q  <= out_opd_d;
            out_pc_q   <= out_pc_d;
            out_wide_q <= out_wide_d;
        end
    end

    assign dec_valid_o     = (state_q == S_OUT);
    assign dec_pc_o        = out_pc_q;
    assign dec_class_o     = out_q.cls;
    assign dec_aluop_o     = out_q.aluop;
    assign dec_cmptype_o   = out_q.cmptype;
    assign dec_lvaidx_o    = LVA_W'(out_q.lvaidx);
    assign dec_constval_o  = out_q.constval;
    assign dec_operand_o   = out_opd_q;
    assign dec_argc_o      = out_q.argc;
    assign dec_stackargs_o = out_q.stackargs;
    assign dec_stackwb_o   = out_q.stackwb;
    assign dec_wide_o      = out_wide_q;
    assign dec_illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_bytecode_decode_stage.sv
// Directed bench for bytecode_decode_stage: hand-computed vectors, one check task.
module tb_bytecode_decode_stage;
    import decode_pkg::*;

    logic         clk, rst_n, in_valid, in_ready, flush, dec_valid, dec_ready;
    logic [7:0]   in_byte;
    logic [15:0]  flush_pc, dec_pc;
    instr_class_e dec_class;
    logic [3:0]   dec_aluop, dec_cmptype;
    logic [7:0]   dec_lvaidx;
    logic [2:0]   dec_constval, dec_argc;
    logic [31:0]  dec_operand;
    logic [1:0]   dec_stackargs;
    logic         dec_stackwb, dec_wide, dec_illegal;

    // Second instance with WIDE disabled, fed the same byte stream.
    logic         nw_in_ready, nw_valid, nw_stackwb, nw_wide, nw_illegal;
    logic [15:0]  nw_pc;
    instr_class_e nw_class;
    logic [3:0]   nw_aluop, nw_cmptype;
    logic [7:0]   nw_lvaidx;
    logic [2:0]   nw_constval, nw_argc;
    logic [31:0]  nw_operand;
    logic [1:0]   nw_stackargs;

    int n_chk = 0;
    int n_bad = 0;

    bytecode_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_byte_i(in_byte), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .flush_i(flush), .flush_pc_i(flush_pc),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .dec_pc_o(dec_pc),
        .dec_class_o(dec_class), .dec_aluop_o(dec_aluop), .dec_cmptype_o(dec_cmptype),
        .dec_lvaidx_o(dec_lvaidx), .dec_constval_o(dec_constval), .dec_operand_o(dec_operand),
        .dec_argc_o(dec_argc), .dec_stackargs_o(dec_stackargs), .dec_stackwb_o(dec_stackwb),
        .dec_wide_o(dec_wide), .dec_illegal_o(dec_illegal)
    );

    bytecode_decode_stage #(.ENABLE_WIDE(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .in_byte_i(in_byte), .in_valid_i(in_valid),
        .in_ready_o(nw_in_ready), .flush_i(flush), .flush_pc_i(flush_pc),
        .dec_valid_o(nw_valid), .dec_ready_i(dec_ready), .dec_pc_o(nw_pc),
        .dec_class_o(nw_class), .dec_aluop_o(nw_aluop), .dec_cmptype_o(nw_cmptype),
        .dec_lvaidx_o(nw_lvaidx), .dec_constval_o(nw_constval), .dec_operand_o(nw_operand),
        .dec_argc_o(nw_argc), .dec_stackargs_o(nw_stackargs), .dec_stackwb_o(nw_stackwb),
        .dec_wide_o(nw_wide), .dec_illegal_o(nw_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one byte once the stage is ready; returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        if (!in_ready) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
        in_byte  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_byte = '0; in_valid = 1'b0; flush = 1'b0; flush_pc = '0; dec_ready = 1'b1;
        repeat (2) step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_valid",    {63'd0, dec_valid}, 64'd0);
        chk("rst_class",    dec_class, CLS_NOP);
        chk("rst_pc_opd",   {dec_pc, dec_operand}, 64'd0);
        rst_n = 1'b1;

        // ICONST_M1
        send_byte(8'h02);
        chk("iconst_valid", {63'd0, dec_valid}, 64'd1);
        chk("iconst_class", dec_class, CLS_CONSTPUSH);
        chk("iconst_fields", {dec_constval, dec_argc, dec_stackwb, dec_pc}, {3'b111, 3'd0, 1'b1, 16'd0});
        chk("out_no_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("bubble", {dec_valid, in_ready}, {1'b0, 1'b1});

        // SIPUSH with idle gaps, then a NOP to observe the following PC
        do_reset();
        send_byte(8'h11); step();
        chk("gap_valid", {63'd0, dec_valid}, 64'd0);
        send_byte(8'h12); step();
        send_byte(8'h34);
        chk("sipush_valid", {63'd0, dec_valid}, 64'd1);
        chk("sipush_class", dec_class, CLS_ARGPUSH);
        chk("sipush_fields", {dec_operand, dec_argc, dec_pc}, {32'h0000_1234, 3'd2, 16'd0});
        send_byte(8'h00);
        chk("nop_pc", {dec_valid, dec_illegal, dec_pc}, {1'b1, 1'b0, 16'd3});

        // WIDE IINC; the WIDE-disabled copy must flag C4 itself
        send_byte(8'hC4);
        chk("wide_pending", {63'd0, dec_valid}, 64'd0);
        chk("nw_c4_illegal", {nw_valid, nw_illegal, nw_argc, nw_wide}, {1'b1, 1'b1, 3'd0, 1'b0});
        chk("nw_c4_class", nw_class, CLS_NOP);
        send_byte(8'h84); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFE);
        chk("wiinc_class", dec_class, CLS_IINC);
        chk("wiinc_fields", {dec_valid, dec_wide, dec_illegal, dec_lvaidx, dec_argc, dec_pc},
            {1'b1, 1'b1, 1'b0, 8'h02, 3'd4, 16'd4});
        chk("wiinc_operand", dec_operand, 32'h0102_FFFE);
        step();

        // IF_ICMPLT under 5 cycles of backpressure
        dec_ready = 1'b0;
        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h08);
        chk("cmp_class", dec_class, CLS_CMP);
        chk("cmp_fields", {dec_cmptype, dec_stackargs, dec_argc}, {1'b1, CMP_LT, 2'd2, 3'd2});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cmp_hold", {dec_valid, in_ready, dec_operand, dec_pc}, {1'b1, 1'b0, 32'h8, 16'd10});
        end
        dec_ready = 1'b1;
        step();
        chk("cmp_release", {dec_valid, in_ready}, {1'b0, 1'b1});

        // Flush in the middle of GOTO's operands, with a byte offered that same cycle
        send_byte(8'hA7); send_byte(8'h00);
        in_byte = 8'h55; in_valid = 1'b1; flush = 1'b1; flush_pc = 16'h0040;
        #1 chk("flush_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_valid", {63'd0, dec_valid}, 64'd0);
        step();
        chk("flush_no_valid2", {63'd0, dec_valid}, 64'd0);
        send_byte(8'h1C);
        chk("flush_pc", {dec_valid, dec_pc}, {1'b1, 16'h0040});
        chk("iload2_class", dec_class, CLS_LVAREAD);
        chk("iload2_fields", {dec_lvaidx, dec_argc, dec_stackwb}, {8'd2, 3'd0, 1'b1});
        step();

        // Undefined opcode, held in S_OUT, then async reset
        dec_ready = 1'b0;
        send_byte(8'hFF);
        chk("ff_illegal", {dec_valid, dec_illegal, dec_argc}, {1'b1, 1'b1, 3'd0});
        chk("ff_class", dec_class, CLS_NOP);
        chk("ff_no_x", {63'd0, $isunknown({dec_pc, dec_class, dec_aluop, dec_cmptype, dec_lvaidx,
            dec_constval, dec_operand, dec_argc, dec_stackargs, dec_stackwb, dec_wide})}, 64'd0);
        step();
        chk("ff_hold", {dec_valid, dec_illegal}, {1'b1, 1'b1});
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", {dec_valid, dec_illegal, in_ready, dec_pc}, {1'b0, 1'b0, 1'b0, 16'd0});
        chk("async_rst_class", dec_class, CLS_NOP);
        step();
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
